// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants and the sync bundle type
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL  = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL  = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam int VGA_HS_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int VGA_VS_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    typedef struct packed {
        logic hs;
        logic vs;
        logic von;
    } sync_bundle_t;

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: ce-gated shift register of sync bundles with a reset load value
import vga_pkg::*;

module vga_sync_delay #(
    parameter int           DEPTH   = 2,
    parameter sync_bundle_t RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ce,
    input  sync_bundle_t d,
    output sync_bundle_t q
);

    if (DEPTH == 0) begin : g_pass
        assign q = d;
    end else begin : g_shift
        sync_bundle_t stage_q [DEPTH];
        // shift one stage per pixel; every stage reloads the idle value on reset
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
            end else if (ce) begin
                stage_q[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end
        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line counters with delayed hsync, vsync and video_on
import vga_pkg::*;

module vga_timing_gen #(
    parameter int   H_VISIBLE = VGA_H_VISIBLE,
    parameter int   H_FRONT   = VGA_H_FRONT,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_BACK    = VGA_H_BACK,
    parameter int   V_VISIBLE = VGA_V_VISIBLE,
    parameter int   V_FRONT   = VGA_V_FRONT,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_BACK    = VGA_V_BACK,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   PIPE_DLY  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_ce,
    output logic [COORD_W-1:0] pixel_column,
    output logic [COORD_W-1:0] pixel_row,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam sync_bundle_t IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, von: 1'b0};

    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
        $error("vga_timing_gen: timing totals do not fit the coordinate width");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be within 0..7");
    end

    logic [COORD_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic               frame_start_q, frame_start_d;
    logic               h_wrap, v_wrap;
    sync_bundle_t       raw, dly;

    // next counter values and the undelayed sync/active flags for the current position
    always_comb begin
        h_wrap        = h_cnt_q == COORD_W'(H_TOTAL - 1);
        v_wrap        = v_cnt_q == COORD_W'(V_TOTAL - 1);
        h_cnt_d       = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d       = !h_wrap ? v_cnt_q : v_wrap ? '0 : v_cnt_q + 1'b1;
        frame_start_d = pix_ce && h_wrap && v_wrap;
        raw.von       = (h_cnt_q < COORD_W'(H_VISIBLE)) && (v_cnt_q < COORD_W'(V_VISIBLE));
        raw.hs        = (h_cnt_q >= COORD_W'(HS_START) && h_cnt_q < COORD_W'(HS_END)) ? SYNC_POL : ~SYNC_POL;
        raw.vs        = (v_cnt_q >= COORD_W'(VS_START) && v_cnt_q < COORD_W'(VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    // counters advance on pixel enables; frame_start is a single-clk pulse after the frame wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
            if (pix_ce) begin
                h_cnt_q <= h_cnt_d;
                v_cnt_q <= v_cnt_d;
            end
        end
    end

    vga_sync_delay #(
        .DEPTH   (PIPE_DLY),
        .RST_VAL (IDLE)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .ce    (pix_ce),
        .d     (raw),
        .q     (dly)
    );

    assign pixel_column = h_cnt_q;
    assign pixel_row    = v_cnt_q;
    assign hsync        = dly.hs;
    assign vsync        = dly.vs;
    assign video_on     = dly.von;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized pixel-enable stimulus against a position-based timing model
module tb_vga_timing_gen;

    localparam int FR_A = 800 * 525;
    localparam int FR_B = 32 * 19;
    localparam int FR_C = 24 * 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_ce = 1'b0;

    logic [9:0] col_a, row_a, col_b, row_b, col_c, row_c;
    logic hs_a, vs_a, von_a, fs_a;
    logic hs_b, vs_b, von_b, fs_b;
    logic hs_c, vs_c, von_c, fs_c;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pix = 0;
    logic valid = 1'b0;
    logic efs_a = 1'b0, efs_b = 1'b0, efs_c = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .pixel_column(col_a), .pixel_row(row_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(von_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_POL(1'b1), .PIPE_DLY(0)
    ) u_b (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .pixel_column(col_b), .pixel_row(row_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(von_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_POL(1'b0), .PIPE_DLY(7)
    ) u_c (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .pixel_column(col_c), .pixel_row(row_c),
        .hsync(hs_c), .vsync(vs_c), .video_on(von_c), .frame_start(fs_c)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // outputs implied by n pixel enables since reset, for a given timing set
    function automatic logic [22:0] model(input int n, input int hv, input int hf, input int hs,
                                          input int hb, input int vv, input int vf, input int vs,
                                          input int vb, input int d, input logic pol);
        int ht = hv + hf + hs + hb;
        int vt = vv + vf + vs + vb;
        int p = n - d;
        int c, r;
        logic e_hs, e_vs, e_von;
        e_hs = ~pol;
        e_vs = ~pol;
        e_von = 1'b0;
        if (p >= 0) begin
            c = p % ht;
            r = (p / ht) % vt;
            e_von = c < hv && r < vv;
            e_hs = (c >= hv + hf && c < hv + hf + hs) ? pol : ~pol;
            e_vs = (r >= vv + vf && r < vv + vf + vs) ? pol : ~pol;
        end
        return {10'(n % ht), 10'((n / ht) % vt), e_hs, e_vs, e_von};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            n_pix <= 0;
            valid <= 1'b1;
            efs_a <= 1'b0;
            efs_b <= 1'b0;
            efs_c <= 1'b0;
        end else begin
            efs_a <= pix_ce && ((n_pix + 1) % FR_A == 0);
            efs_b <= pix_ce && ((n_pix + 1) % FR_B == 0);
            efs_c <= pix_ce && ((n_pix + 1) % FR_C == 0);
            if (pix_ce) n_pix <= n_pix + 1;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            chk("model_a", {8'd0, col_a, row_a, hs_a, vs_a, von_a, fs_a},
                {8'd0, model(n_pix, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0), efs_a});
            chk("model_b", {8'd0, col_b, row_b, hs_b, vs_b, von_b, fs_b},
                {8'd0, model(n_pix, 20, 3, 5, 4, 12, 2, 2, 3, 0, 1'b1), efs_b});
            chk("model_c", {8'd0, col_c, row_c, hs_c, vs_c, von_c, fs_c},
                {8'd0, model(n_pix, 16, 2, 4, 2, 10, 1, 2, 2, 7, 1'b0), efs_c});
        end
    end

    task automatic tick(input logic ce, input logic rst);
        pix_ce = ce;
        reset = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt_von, cnt_hs, cnt_vs;
        repeat (3) tick(1'b0, 1'b1);
        chk("reset_state_a", {col_a, row_a, hs_a, vs_a, von_a, fs_a}, {10'd0, 10'd0, 4'b1100});
        tick(1'b1, 1'b0);
        chk("von_before_dly", {22'd0, col_a, von_a}, {22'd0, 10'd1, 1'b0});
        tick(1'b1, 1'b0);
        chk("von_rise_col2", {22'd0, col_a, von_a}, {22'd0, 10'd2, 1'b1});
        repeat (639) tick(1'b1, 1'b0);
        chk("von_col641", {22'd0, col_a, von_a}, {22'd0, 10'd641, 1'b1});
        tick(1'b1, 1'b0);
        chk("von_fall_col642", {22'd0, col_a, von_a}, {22'd0, 10'd642, 1'b0});
        repeat (15) tick(1'b1, 1'b0);
        chk("hs_col657", {22'd0, col_a, hs_a}, {22'd0, 10'd657, 1'b1});
        tick(1'b1, 1'b0);
        chk("hs_fall_col658", {22'd0, col_a, hs_a}, {22'd0, 10'd658, 1'b0});
        repeat (442) tick(1'b1, 1'b0);
        repeat (50) tick(1'b0, 1'b0);
        chk("hold_frozen", {col_a, row_a, hs_a, vs_a, von_a, fs_a}, {10'd300, 10'd1, 4'b1110});
        tick(1'b1, 1'b0);
        chk("resume_col301", {22'd0, col_a}, {22'd0, 10'd301});
        repeat (99) tick(1'b1, 1'b0);
        chk("pre_reset_pos", {12'd0, col_a, row_a}, {12'd0, 10'd400, 10'd1});
        tick(1'b1, 1'b1);
        chk("reset_over_ce", {col_a, row_a, hs_a, vs_a, von_a, fs_a}, {10'd0, 10'd0, 4'b1100});
        tick(1'b1, 1'b0);
        chk("reset_von_1", {31'd0, von_a}, 32'd0);
        tick(1'b1, 1'b0);
        chk("reset_von_2", {31'd0, von_a}, 32'd1);
        tick(1'b0, 1'b1);
        cnt_von = 0;
        cnt_hs = 0;
        cnt_vs = 0;
        for (int i = 0; i < FR_B; i++) begin
            cnt_von += int'(von_b);
            cnt_hs += int'(hs_b);
            cnt_vs += int'(vs_b);
            if (i == FR_B - 1) chk("b_last_pos", {12'd0, col_b, row_b}, {12'd0, 10'd31, 10'd18});
            tick(1'b1, 1'b0);
        end
        chk("b_von_count", cnt_von, 240);
        chk("b_hs_count", cnt_hs, 95);
        chk("b_vs_count", cnt_vs, 64);
        chk("b_frame_start", {col_b, row_b, 11'd0, fs_b}, {10'd0, 10'd0, 12'd1});
        tick(1'b0, 1'b0);
        chk("b_frame_start_end", {31'd0, fs_b}, 32'd0);
        for (int i = 0; i < 2000; i++) tick(i % 4 == 0, 1'b0);
        for (int i = 0; i < 8000; i++) tick($urandom_range(0, 1) == 1, $urandom_range(0, 999) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
